// File: rtl/mem_pkg.sv
// Shared types for the LC-3b memory arbiter: port-2 FSM states, requester ownership, bus widths.
// No logic here; no latency or backpressure of its own.
package mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_MEM = 1'b0,
        OWN_LD  = 1'b1
    } owner_t;

    typedef struct packed {
        logic              we;
        logic              byte_acc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        owner_t            owner;
    } req_t;

endpackage

// File: rtl/byte_steer.sv
// LC-3b byte-lane steering: store lane replication, write-enable selection, load extract, misalign flag.
// Purely combinational, zero latency; no backpressure.
module byte_steer
    import mem_pkg::*;
(
    input  logic              we,
    input  logic              byte_acc,
    input  logic              addr0,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] lane_wdata,
    output logic [DATA_W-1:0] load_data,
    output logic              we_low,
    output logic              we_hi,
    output logic              misalign
);

    always_comb begin
        misalign   = ~byte_acc & addr0;
        lane_wdata = byte_acc ? {wdata[7:0], wdata[7:0]} : wdata;
        we_low     = we & ~misalign & (~byte_acc | ~addr0);
        we_hi      = we & ~misalign & (~byte_acc | addr0);

        // Byte loads are zero-extended; sign extension belongs to the datapath.
        load_data = '0;
        if (!we && !misalign) begin
            if (byte_acc) begin
                load_data = {8'h00, (addr0 ? mem_rdata[15:8] : mem_rdata[7:0])};
            end else begin
                load_data = mem_rdata;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Dual-port BRAM sequencer: port 1 fetch (valid 2 cycles after request), port 2 shared MEM/loader.
// Port-2 Gnt->Done is 2 cycles; requesters hold Req until Gnt; MEM has priority with loader anti-starvation.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              fetchReq,
    input  logic [ADDR_W-1:0] fetchAddr,
    output logic              fetchValid,
    output logic [DATA_W-1:0] fetchData,
    input  logic              memReq,
    input  logic              ldReq,
    input  logic              memWe,
    input  logic              ldWe,
    input  logic              memByte,
    input  logic              ldByte,
    input  logic [ADDR_W-1:0] memAddr,
    input  logic [ADDR_W-1:0] ldAddr,
    input  logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] ldWdata,
    output logic              memGnt,
    output logic              ldGnt,
    output logic              memDone,
    output logic              ldDone,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mAddr1,
    output logic [ADDR_W-1:0] mAddr2,
    output logic              mEn,
    output logic              mWeLow,
    output logic              mWeHi,
    output logic [DATA_W-1:0] mDataIn,
    input  logic [DATA_W-1:0] mDataOut1,
    input  logic [DATA_W-1:0] mDataOut2
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    state_t            state;
    state_t            state_nxt;
    req_t              cur;
    req_t              req_sel;
    logic              run;
    logic [CNT_W-1:0]  starve;
    logic              fv1;
    logic              fv2;
    logic              can_accept;
    logic              ld_win;
    logic              mem_gnt;
    logic              ld_gnt;
    logic              in_access;
    logic              in_resp;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] load_data;
    logic              we_low;
    logic              we_hi;
    logic              misalign;

    always_comb begin
        state_nxt  = state;
        mem_gnt    = 1'b0;
        ld_gnt     = 1'b0;
        ld_win     = ldReq && (!memReq || (starve == STARVE_MAX));
        can_accept = run && ((state == IDLE) || (state == RESP));

        if (can_accept && (memReq || ldReq)) begin
            ld_gnt  = ld_win;
            mem_gnt = !ld_win;
        end

        case (state)
            IDLE:    if (mem_gnt || ld_gnt) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = (mem_gnt || ld_gnt) ? ACCESS : IDLE;
            default: state_nxt = IDLE;
        endcase

        req_sel.we       = ld_gnt ? ldWe    : memWe;
        req_sel.byte_acc = ld_gnt ? ldByte  : memByte;
        req_sel.addr     = ld_gnt ? ldAddr  : memAddr;
        req_sel.wdata    = ld_gnt ? ldWdata : memWdata;
        req_sel.owner    = ld_gnt ? OWN_LD  : OWN_MEM;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state  <= IDLE;
            cur    <= '0;
            run    <= 1'b0;
            starve <= '0;
            mAddr1 <= '0;
            fv1    <= 1'b0;
            fv2    <= 1'b0;
        end else begin
            run   <= 1'b1;
            state <= state_nxt;
            if (mem_gnt || ld_gnt) cur <= req_sel;

            // Counts MEM wins only while the loader is actually waiting.
            if (!ldReq || ld_gnt) begin
                starve <= '0;
            end else if (mem_gnt && (starve != STARVE_MAX)) begin
                starve <= starve + CNT_W'(1);
            end

            if (fetchReq) mAddr1 <= fetchAddr;
            fv1 <= fetchReq;
            fv2 <= fv1;
        end
    end

    byte_steer u_steer (
        .we        (cur.we),
        .byte_acc  (cur.byte_acc),
        .addr0     (cur.addr[0]),
        .wdata     (cur.wdata),
        .mem_rdata (mDataOut2),
        .lane_wdata(lane_wdata),
        .load_data (load_data),
        .we_low    (we_low),
        .we_hi     (we_hi),
        .misalign  (misalign)
    );

    always_comb begin
        in_access  = (state == ACCESS);
        in_resp    = (state == RESP);
        mEn        = run;
        fetchValid = fv2;
        fetchData  = fv2 ? mDataOut1 : '0;
        memGnt     = mem_gnt;
        ldGnt      = ld_gnt;
        mAddr2     = in_access ? cur.addr : '0;
        mDataIn    = in_access ? lane_wdata : '0;
        mWeLow     = in_access & we_low;
        mWeHi      = in_access & we_hi;
        memDone    = in_resp & (cur.owner == OWN_MEM);
        ldDone     = in_resp & (cur.owner == OWN_LD);
        rdata      = in_resp ? load_data : '0;
        err        = in_resp & misalign;
    end

endmodule
